// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data load/store share one
// memory port, with one transaction outstanding, fetch anti-starvation and an ack timeout.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_err,
  output logic [1:0]  fsm_state
);

  // Handshakes: if_req/dm_req stay high until their one-cycle valid pulse;
  // mem_req and its address/data stay constant until mem_ack (or timeout).
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          fetch_win;

  assign fetch_win = if_req && (!dm_req || (starve_cnt == STARVE_MAX));
  assign stall_f   = if_req & ~if_valid;
  assign stall_m   = dm_req & ~dm_valid;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fetch_win) begin
            state      <= FETCH;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr & ~32'h3;
            starve_cnt <= '0;
          end else if (dm_req) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr & ~32'h3;
            mem_wdata <= dm_wdata;
            if (if_req && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        FETCH: begin
          if (mem_ack || (tmo_cnt == TMO_LAST)) begin
            if (mem_ack) if_rdata <= mem_rdata;
            else         mem_err  <= 1'b1;
            if_valid <= 1'b1;
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DATA: begin
          if (mem_ack || (tmo_cnt == TMO_LAST)) begin
            // Stores complete without touching the load data register.
            if (mem_ack && !mem_we) dm_rdata <= mem_rdata;
            if (!mem_ack)           mem_err  <= 1'b1;
            dm_valid <= 1'b1;
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, single fetch, priority, starvation,
// timeout and reset-during-transaction scenarios against hand-computed values.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_f;
  logic        stall_m;
  logic        mem_err;
  logic [1:0]  fsm_state;

  int          checks;
  int          errors;

  // memory responder controls
  logic        resp_en;
  int          ack_lat;
  logic [31:0] resp_data;
  logic        force_ack;
  logic [31:0] force_data;
  int          wcnt;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .mem_err   (mem_err),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: acks ack_lat cycles after mem_req rises, or on force_ack.
  initial begin
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) wcnt++;
      else         wcnt = 0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = force_data;
      end else if (resp_en && mem_req && (wcnt == ack_lat)) begin
        mem_ack   = 1'b1;
        mem_rdata = resp_data;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata got %h exp 0", if_rdata); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_dm_rdata got %h exp 0", dm_rdata); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
    checks++; if (dm_valid !== 1'b0) begin errors++; $display("FAIL rst_dm_valid got %b exp 0", dm_valid); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err got %b exp 0", mem_err); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", fsm_state); end
    checks++; if ({stall_f, stall_m} !== 2'b00) begin errors++; $display("FAIL rst_stalls got %b exp 00", {stall_f, stall_m}); end
    reset = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b exp 0", mem_req); end
  endtask

  task automatic test_single_fetch();
    resp_en   = 1'b1;
    ack_lat   = 1;
    resp_data = 32'hE3A01005;
    if_addr   = 32'h00000106;
    if_req    = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sf_mem_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h00000104) begin errors++; $display("FAIL sf_mem_addr got %h exp 00000104", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sf_mem_we got %b exp 0", mem_we); end
    checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL sf_state got %0d exp 1", fsm_state); end
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL sf_stall_f got %b exp 1", stall_f); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL sf_early_valid got %b exp 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL sf_if_valid got %b exp 1", if_valid); end
    checks++; if (if_rdata !== 32'hE3A01005) begin errors++; $display("FAIL sf_if_rdata got %h exp E3A01005", if_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sf_mem_req_done got %b exp 0", mem_req); end
    checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL sf_stall_f_done got %b exp 0", stall_f); end
    if_req = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL sf_valid_pulse got %b exp 0", if_valid); end
    checks++; if (if_rdata !== 32'hE3A01005) begin errors++; $display("FAIL sf_rdata_hold got %h exp E3A01005", if_rdata); end
  endtask

  task automatic test_simultaneous();
    resp_data = 32'h11112222;
    if_addr   = 32'h00000040;
    if_req    = 1'b1;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h00000020;
    dm_wdata  = 32'hDEADBEEF;
    tick();
    checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL sim_data_first got %0d exp 2", fsm_state); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sim_mem_we got %b exp 1", mem_we); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL sim_mem_addr got %h exp 00000020", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_mem_wdata got %h exp DEADBEEF", mem_wdata); end
    checks++; if ({stall_f, stall_m} !== 2'b11) begin errors++; $display("FAIL sim_stalls got %b exp 11", {stall_f, stall_m}); end
    tick();
    checks++; if (dm_valid !== 1'b1) begin errors++; $display("FAIL sim_dm_valid got %b exp 1", dm_valid); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL sim_store_rdata got %h exp 0", dm_rdata); end
    checks++; if ({stall_f, stall_m} !== 2'b10) begin errors++; $display("FAIL sim_stalls2 got %b exp 10", {stall_f, stall_m}); end
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL sim_fetch_next got %0d exp 1", fsm_state); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL sim_fetch_addr got %h exp 00000040", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sim_fetch_we got %b exp 0", mem_we); end
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL sim_stall_f3 got %b exp 1", stall_f); end
    tick();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL sim_if_valid got %b exp 1", if_valid); end
    checks++; if (if_rdata !== 32'h11112222) begin errors++; $display("FAIL sim_if_rdata got %h exp 11112222", if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic       exp_fetch [6];
    logic       got_fetch [6];
    logic       prev_req;
    int         n;
    exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    resp_data = 32'h12345678;
    if_addr   = 32'h00000080;
    dm_addr   = 32'h00000100;
    dm_we     = 1'b0;
    if_req    = 1'b1;
    dm_req    = 1'b1;
    prev_req  = mem_req;
    n         = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (mem_req && !prev_req) begin
        got_fetch[n] = (mem_addr == 32'h80);
        n++;
      end
      prev_req = mem_req;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL starve_grant_count got %0d exp 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_fetch[i] !== exp_fetch[i]) begin
        errors++;
        $display("FAIL starve_grant%0d got fetch=%b exp fetch=%b", i, got_fetch[i], exp_fetch[i]);
      end
    end
    tick();
    tick();
    checks++; if (dm_rdata !== 32'h12345678) begin errors++; $display("FAIL starve_dm_rdata got %h exp 12345678", dm_rdata); end
    checks++; if (if_rdata !== 32'h12345678) begin errors++; $display("FAIL starve_if_rdata got %h exp 12345678", if_rdata); end
  endtask

  task automatic test_timeout();
    int cnt;
    resp_en = 1'b0;
    dm_addr = 32'h00000200;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    tick();
    checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL tmo_grant got %0d exp 2", fsm_state); end
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cnt++;
      if (dm_valid) break;
      if (cnt == 14) begin
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err got %b exp 0", mem_err); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL tmo_hold_req got %b exp 1", mem_req); end
      end
    end
    checks++; if (cnt != 15) begin errors++; $display("FAIL tmo_cycles got %0d exp 15", cnt); end
    checks++; if (dm_valid !== 1'b1) begin errors++; $display("FAIL tmo_dm_valid got %b exp 1", dm_valid); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL tmo_mem_err got %b exp 1", mem_err); end
    checks++; if (dm_rdata !== 32'h12345678) begin errors++; $display("FAIL tmo_rdata got %h exp 12345678", dm_rdata); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL tmo_state got %0d exp 0", fsm_state); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tmo_mem_req got %b exp 0", mem_req); end
    dm_req     = 1'b0;
    force_data = 32'hBADBAD00;
    force_ack  = 1'b1;
    tick();
    force_ack = 1'b0;
    checks++; if (dm_rdata !== 32'h12345678) begin errors++; $display("FAIL idle_ack_dm_rdata got %h exp 12345678", dm_rdata); end
    checks++; if (if_rdata !== 32'h12345678) begin errors++; $display("FAIL idle_ack_if_rdata got %h exp 12345678", if_rdata); end
    tick();
    checks++; if ({if_valid, dm_valid} !== 2'b00) begin errors++; $display("FAIL idle_ack_valid got %b exp 00", {if_valid, dm_valid}); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", mem_err); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL idle_ack_state got %0d exp 0", fsm_state); end
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    dm_addr = 32'h00000300;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_grant got %b exp 1", mem_req); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_async_req got %b exp 0", mem_req); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rm_async_state got %0d exp 0", fsm_state); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rm_err_clear got %b exp 0", mem_err); end
    dm_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    force_data = 32'hCAFEF00D;
    force_ack  = 1'b1;
    tick();
    force_ack = 1'b0;
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL rm_late_ack_rdata got %h exp 0", dm_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_late_ack_req got %b exp 0", mem_req); end
    tick();
    checks++; if ({if_valid, dm_valid} !== 2'b00) begin errors++; $display("FAIL rm_no_valid got %b exp 00", {if_valid, dm_valid}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rm_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rm_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rm_if_rdata got %h exp 0", if_rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_mem_we got %b exp 0", mem_we); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rm_state got %0d exp 0", fsm_state); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    resp_en    = 1'b0;
    ack_lat    = 1;
    resp_data  = 32'h0;
    force_ack  = 1'b0;
    force_data = 32'h0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
